// File: rtl/vehicle_counter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vehicle_counter_if                                                  |
// | Loop-detector inputs, clear request and count/flag outputs.         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface vehicle_counter_if;
  logic       sensor_arrive;
  logic       sensor_depart;
  logic       clear;
  logic [4:0] NO_of_vehical;
  logic       count_changed;
  logic       overflow;
  logic       underflow;

  modport master (
    output sensor_arrive, sensor_depart, clear,
    input  NO_of_vehical, count_changed, overflow, underflow
  );

  modport slave (
    input  sensor_arrive, sensor_depart, clear,
    output NO_of_vehical, count_changed, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/vehicle_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vehicle_counter                                                     |
// | Debounced arrival/departure loops driving a saturating 0..31 count. |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module vehicle_counter #(
  parameter int DEBOUNCE = 4
) (
  input logic              clk,
  input logic              rst,
  vehicle_counter_if.slave bus
);

  localparam logic [3:0] c_DEBOUNCE_CNT = 4'(DEBOUNCE);
  localparam logic [4:0] c_COUNT_MAX    = 5'd31;

  if ((DEBOUNCE < 1) || (DEBOUNCE > 15)) begin : g_bad_debounce
    $error("vehicle_counter: DEBOUNCE must be in 1..15");
  end

  typedef enum logic [1:0] {
    LOW_STABLE   = 2'd0,
    CONFIRM_HIGH = 2'd1,
    HIGH_STABLE  = 2'd2,
    CONFIRM_LOW  = 2'd3
  } deb_state_t;

  // Channel 0 is the arrival loop, channel 1 the departure loop.
  logic [1:0] w_raw;
  logic [1:0] w_evt;

  assign w_raw = {bus.sensor_depart, bus.sensor_arrive};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic [1:0] r_sync;
    deb_state_t r_state;
    deb_state_t w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_sync;
    logic       w_evt_c;

    assign w_sync = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync  <= 2'b00;
        r_state <= LOW_STABLE;
        r_cnt   <= 4'd0;
      end else begin
        r_sync  <= {r_sync[0], w_raw[g]};
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_evt_c      = 1'b0;
      unique case (r_state)
        LOW_STABLE: begin
          if (w_sync) begin
            w_state_next = CONFIRM_HIGH;
            w_cnt_next   = 4'd1;
          end
        end
        CONFIRM_HIGH: begin
          if (!w_sync) begin
            w_state_next = LOW_STABLE;
            w_cnt_next   = 4'd0;
          end else if (r_cnt == c_DEBOUNCE_CNT) begin
            w_state_next = HIGH_STABLE;
            w_evt_c      = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
        HIGH_STABLE: begin
          if (!w_sync) begin
            w_state_next = CONFIRM_LOW;
            w_cnt_next   = 4'd1;
          end
        end
        CONFIRM_LOW: begin
          if (w_sync) begin
            w_state_next = HIGH_STABLE;
          end else if (r_cnt == c_DEBOUNCE_CNT) begin
            w_state_next = LOW_STABLE;
            w_cnt_next   = 4'd0;
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
        default: begin
          w_state_next = LOW_STABLE;
          w_cnt_next   = 4'd0;
        end
      endcase
    end

    assign w_evt[g] = w_evt_c;
  end

  logic [4:0] r_count;
  logic [4:0] w_count_next;
  logic       r_overflow;
  logic       w_overflow_next;
  logic       r_underflow;
  logic       w_underflow_next;
  logic       r_change_pend;
  logic       r_count_changed;

  always_comb begin
    w_count_next     = r_count;
    w_overflow_next  = r_overflow;
    w_underflow_next = r_underflow;
    if (bus.clear) begin
      w_count_next     = 5'd0;
      w_overflow_next  = 1'b0;
      w_underflow_next = 1'b0;
    end else if (w_evt[0] && !w_evt[1]) begin
      if (r_count == c_COUNT_MAX) begin
        w_overflow_next = 1'b1;
      end else begin
        w_count_next = r_count + 5'd1;
      end
    end else if (w_evt[1] && !w_evt[0]) begin
      if (r_count == 5'd0) begin
        w_underflow_next = 1'b1;
      end else begin
        w_count_next = r_count - 5'd1;
      end
    end
  end

  // The change flag is staged once so it pulses the cycle after the count moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count         <= 5'd0;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
      r_change_pend   <= 1'b0;
      r_count_changed <= 1'b0;
    end else begin
      r_count         <= w_count_next;
      r_overflow      <= w_overflow_next;
      r_underflow     <= w_underflow_next;
      r_change_pend   <= (w_count_next != r_count);
      r_count_changed <= r_change_pend;
    end
  end

  assign bus.NO_of_vehical = r_count;
  assign bus.count_changed = r_count_changed;
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;

endmodule
`default_nettype wire

// File: doc/vehicle_counter.md
# vehicle_counter

Queue-occupancy counter that produces the 5-bit `NO_of_vehical` count consumed by the traffic-light controller. It takes raw loop-detector levels from an arrival loop and a departure loop, synchronises and debounces each one, and detects vehicle edges. It keeps a saturating up/down count of vehicles waiting on the approach. Flag outputs report change, overflow and underflow events to the controller and to status logic.

## Interface
- `DEBOUNCE`, default 4: consecutive synchronised cycles a loop level must hold before it is accepted; legal range 1..15.
- `clk` input 1: single system clock; all state is updated on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sensor_arrive` input 1: raw, asynchronous arrival-loop level; high means a vehicle is over the loop.
- `sensor_depart` input 1: raw, asynchronous departure-loop level.
- `clear` input 1: synchronous, clk-domain request to zero the count and both flags.
- `NO_of_vehical` output 5: registered vehicle count, 0..31.
- `count_changed` output 1: one-cycle pulse on the edge after `NO_of_vehical` takes a new value.
- `overflow` output 1: sticky; set when an arrival is seen at count 31.
- `underflow` output 1: sticky; set when a departure is seen at count 0.

## Operation
- Reset (asynchronous, takes effect immediately):
  - `NO_of_vehical`=0, `count_changed`=0, `overflow`=0, `underflow`=0.
  - Synchronisers and debounce state return to LOW_STABLE with a zero counter.
- Per channel (arrive, depart): a 2-flop synchroniser feeds a debounce FSM and a 4-bit stability counter.
  - LOW_STABLE: if sync=1, go to CONFIRM_HIGH with counter=1; otherwise stay.
  - CONFIRM_HIGH, sync=1:
    - counter==DEBOUNCE → go to HIGH_STABLE and pulse `evt` for one cycle.
    - otherwise counter+1.
  - CONFIRM_HIGH, sync=0: return to LOW_STABLE and clear the counter (glitch rejected).
  - HIGH_STABLE: if sync=0, go to CONFIRM_LOW with counter=1.
  - CONFIRM_LOW, sync=0: counter==DEBOUNCE → go to LOW_STABLE, no event; otherwise counter+1.
  - CONFIRM_LOW, sync=1: return to HIGH_STABLE.
  - With DEBOUNCE=1, CONFIRM_HIGH exits on its first cycle.
- Exactly one `evt` per accepted low→high transition; a vehicle dwelling on the loop indefinitely counts once.
- Count update, in priority order each cycle:
  - `clear`=1: count←0, `overflow`←0, `underflow`←0. Any same-cycle events are dropped.
  - `evt_a` and `evt_d` together: count unchanged, flags unchanged.
  - `evt_a` only: count<31 → count+1; count==31 → hold 31 and set `overflow`.
  - `evt_d` only: count>0 → count−1; count==0 → hold 0 and set `underflow`.
- `count_changed` is registered and equals (next count ≠ current count). Saturated holds and clear-at-zero do not pulse it.
- `clear` does not disturb the debounce FSMs; an event already in flight is counted after the clear.
- Reset mid-operation: all state is lost immediately. A loop held high through reset release is seen as a new arrival after the debounce period.

## Timing
- Raw input high from before edge E0 and held: sync output high after E1.
  - FSM enters CONFIRM_HIGH at E2.
  - `evt` is high during the cycle after edge E(1+DEBOUNCE).
  - Count updates at E(2+DEBOUNCE); `count_changed` is high after E(3+DEBOUNCE) for one cycle.
- Latency from raw assertion to the new count: DEBOUNCE+2 edges; for DEBOUNCE=4 that is 6 edges.
- A raw pulse of DEBOUNCE synchronised cycles or fewer is never counted.
- Minimum separable vehicles per loop: high ≥ DEBOUNCE+1 cycles, then low ≥ DEBOUNCE+1 cycles.
- `clear` takes effect on the edge at which it is sampled; one cycle of assertion is sufficient.
- No combinational path from any input to any output.

## Test plan
- Reset, DEBOUNCE=4: hold `sensor_arrive` high 20 cycles → `NO_of_vehical` goes 0→1 exactly 6 edges after the first sampling edge; `count_changed` pulses once; no further increments.
- Glitch rejection: `sensor_arrive` high for 3 cycles, 10 times → count stays 0, `count_changed` never asserts.
- Saturation: 33 clean arrivals → count reaches 31; `overflow` rises on the 32nd arrival and stays set; no `count_changed` on the 32nd or 33rd. Then `clear` → count 0, `overflow` 0, one `count_changed` pulse.
- Underflow: from count 0, one clean departure → count stays 0, `underflow`=1. Then 2 arrivals and 1 departure → count=1.
- Simultaneous events: identically timed clean pulses on both loops at count 5 → count stays 5, no `count_changed`, no flags. Repeat with `clear` asserted in the event cycle → count 0.
- Asynchronous reset at count 12, mid-CONFIRM_HIGH → outputs go to 0 without a clock edge. With the arrive loop held high through release, count becomes 1 at DEBOUNCE+2 edges after release.
